// File: rtl/eggtimer_ctrl_if.sv
// Egg-timer control bundle: pulse/button/zero inputs and programmed digits plus status outputs.
// Latency: pure wiring, no storage.
// Backpressure: none; every signal is a level or single-cycle pulse.
interface eggtimer_ctrl_if;
  logic       pulse_1s;
  logic       btn_start;
  logic       btn_min;
  logic       btn_sec;
  logic       count_zero;
  logic [3:0] seconds_prog;
  logic [3:0] tens_seconds_prog;
  logic [3:0] minutes_prog;
  logic [3:0] tens_minutes_prog;
  logic       load;
  logic       count_en;
  logic       display_prog;
  logic       timer_enabled_led;
  logic       timer_on_led;
  logic       alarm;

  // Stimulus side: drives the tick, buttons and zero flag, observes the controller.
  modport master (
    output pulse_1s, btn_start, btn_min, btn_sec, count_zero,
    input  seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
    input  load, count_en, display_prog, timer_enabled_led, timer_on_led, alarm
  );

  // Controller side.
  modport slave (
    input  pulse_1s, btn_start, btn_min, btn_sec, count_zero,
    output seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
    output load, count_en, display_prog, timer_enabled_led, timer_on_led, alarm
  );
endinterface

// File: rtl/eggtimer_ctrl.sv
// Egg-timer controller: button programming of MM:SS, run/pause/alarm FSM and LED drive.
// Latency: button edge acts on the next clock edge; load is a registered one-cycle pulse.
// Backpressure: none; inputs are levels sampled every cycle, outputs are registered/decoded state.
module eggtimer_ctrl #(
  parameter int ALARM_SECS = 30
) (
  input logic           clk,
  input logic           reset,
  eggtimer_ctrl_if.slave bus
);

  localparam int CW = $clog2(ALARM_SECS + 1);

  typedef enum logic [1:0] {PROG, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nxt;
  logic          load_q, load_nxt;
  logic          led_q, led_nxt;
  logic          start_q, min_q, sec_q;
  logic          start_e, min_e, sec_e, any_e;
  logic [3:0]    sec_u, sec_t, min_u, min_t;
  logic [CW-1:0] alarm_cnt;
  logic          prog_nz, alarm_hit;

  assign start_e   = bus.btn_start & ~start_q;
  assign min_e     = bus.btn_min   & ~min_q;
  assign sec_e     = bus.btn_sec   & ~sec_q;
  assign any_e     = start_e | min_e | sec_e;
  // Start decision looks at the stored digits, i.e. before any same-cycle increment.
  assign prog_nz   = |{sec_u, sec_t, min_u, min_t};
  assign alarm_hit = (alarm_cnt == CW'(ALARM_SECS));

  // Previous-cycle button levels; also sampled in reset so held buttons give no edge on release.
  always_ff @(posedge clk) begin
    start_q <= bus.btn_start;
    min_q   <= bus.btn_min;
    sec_q   <= bus.btn_sec;
  end

  // State, load pulse and LED registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= PROG;
      load_q <= 1'b0;
      led_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      load_q <= load_nxt;
      led_q  <= led_nxt;
    end
  end

  // Next-state, load and LED decode.
  always_comb begin
    state_nxt = state;
    load_nxt  = 1'b0;
    led_nxt   = led_q;
    case (state)
      PROG: begin
        if (start_e && prog_nz) begin
          state_nxt = RUN;
          load_nxt  = 1'b1;
        end
      end
      RUN: begin
        // Reaching zero beats a pause request; zero is stale while the counter is loading.
        if (bus.count_zero && !load_q) state_nxt = DONE;
        else if (start_e)               state_nxt = PAUSE;
      end
      PAUSE: begin
        if (start_e)    state_nxt = RUN;
        else if (sec_e) state_nxt = PROG;
      end
      DONE: begin
        if (alarm_hit || any_e) state_nxt = PROG;
      end
      default: state_nxt = PROG;
    endcase

    case (state_nxt)
      PROG:    led_nxt = 1'b0;
      PAUSE:   led_nxt = 1'b1;
      RUN:     led_nxt = (state == RUN)  ? (led_q ^ bus.pulse_1s) : 1'b0;
      DONE:    led_nxt = (state == DONE) ? (led_q ^ bus.pulse_1s) : 1'b1;
      default: led_nxt = 1'b0;
    endcase
  end

  // Programmed digits: BCD increments only while programming, held in every other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_u <= 4'd0;
      sec_t <= 4'd0;
      min_u <= 4'd0;
      min_t <= 4'd0;
    end else if (state == PROG) begin
      if (sec_e) begin
        if (sec_u == 4'd9) begin
          sec_u <= 4'd0;
          sec_t <= (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
        end else begin
          sec_u <= sec_u + 4'd1;
        end
      end
      if (min_e) begin
        if (min_u == 4'd9) begin
          min_u <= 4'd0;
          min_t <= (min_t == 4'd9) ? 4'd0 : min_t + 4'd1;
        end else begin
          min_u <= min_u + 4'd1;
        end
      end
    end
  end

  // Alarm duration counter: held at zero outside DONE, saturates at ALARM_SECS.
  always_ff @(posedge clk) begin
    if (reset || state != DONE) begin
      alarm_cnt <= '0;
    end else if (bus.pulse_1s && !alarm_hit) begin
      alarm_cnt <= alarm_cnt + CW'(1);
    end
  end

  assign bus.seconds_prog      = sec_u;
  assign bus.tens_seconds_prog = sec_t;
  assign bus.minutes_prog      = min_u;
  assign bus.tens_minutes_prog = min_t;
  assign bus.load              = load_q;
  assign bus.count_en          = (state == RUN) && !load_q;
  assign bus.display_prog      = (state == PROG);
  assign bus.timer_enabled_led = (state == RUN) || (state == PAUSE);
  assign bus.timer_on_led      = led_q;
  assign bus.alarm             = (state == DONE);

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Bench for eggtimer_ctrl: directed button/tick sequences, expected outputs queued to a scoreboard.
// Expected vector = {MM:SS BCD, load, count_en, display_prog, enabled_led, on_led, alarm}.
module tb_eggtimer_ctrl;

  typedef struct {
    string       nm;
    logic [21:0] v;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  eggtimer_ctrl_if bus();

  eggtimer_ctrl #(.ALARM_SECS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string nm, input logic [15:0] p,
                    input logic ld, input logic ce, input logic dp,
                    input logic en, input logic led, input logic al);
    exp_t e;
    e.nm = nm;
    e.v  = {p, ld, ce, dp, en, led, al};
    sb.push_back(e);
  endtask

  task automatic press_sec();
    bus.btn_sec = 1'b1; tick();
    bus.btn_sec = 1'b0; tick();
  endtask

  task automatic press_min();
    bus.btn_min = 1'b1; tick();
    bus.btn_min = 1'b0; tick();
  endtask

  task automatic press_start();
    bus.btn_start = 1'b1; tick();
    bus.btn_start = 1'b0; tick();
  endtask

  task automatic pulse();
    bus.pulse_1s = 1'b1; tick();
    bus.pulse_1s = 1'b0; tick();
  endtask

  // Monitor: mid-cycle, compare DUT outputs against every queued expectation.
  always @(negedge clk) begin
    exp_t        e;
    logic [21:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {bus.tens_minutes_prog, bus.minutes_prog, bus.tens_seconds_prog, bus.seconds_prog,
             bus.load, bus.count_en, bus.display_prog, bus.timer_enabled_led,
             bus.timer_on_led, bus.alarm};
      total++;
      if (obs === e.v) passed++;
      else $display("FAIL %s: got %h expected %h", e.nm, obs, e.v);
    end
  end

  initial begin
    reset = 1'b1;
    bus.pulse_1s = 1'b0; bus.btn_start = 1'b0; bus.btn_min = 1'b0;
    bus.btn_sec = 1'b0; bus.count_zero = 1'b0;
    tick(); tick();
    ex("reset", 16'h0000, 0, 0, 1, 0, 0, 0);
    reset = 1'b0; tick();

    // Minutes wrap 99 -> 00.
    repeat (99) press_min();
    ex("min_99", 16'h9900, 0, 0, 1, 0, 0, 0);
    press_min();
    ex("min_wrap", 16'h0000, 0, 0, 1, 0, 0, 0);

    // Seconds wrap 59 -> 00 with no carry, then 75 edges + 3 minutes = 03:15.
    repeat (59) press_sec();
    ex("sec_59", 16'h0059, 0, 0, 1, 0, 0, 0);
    press_sec();
    ex("sec_wrap", 16'h0000, 0, 0, 1, 0, 0, 0);
    repeat (15) press_sec();
    repeat (3) press_min();
    ex("prog_0315", 16'h0315, 0, 0, 1, 0, 0, 0);

    // Simultaneous sec and min edges.
    bus.btn_sec = 1'b1; bus.btn_min = 1'b1; tick();
    bus.btn_sec = 1'b0; bus.btn_min = 1'b0; tick();
    ex("both_inc", 16'h0416, 0, 0, 1, 0, 0, 0);

    reset = 1'b1; tick(); reset = 1'b0; tick();

    // Start at 00:00 is ignored.
    bus.btn_start = 1'b1; tick();
    ex("zero_start", 16'h0000, 0, 0, 1, 0, 0, 0);
    bus.btn_start = 1'b0; tick();

    // Start with simultaneous sec edge: decision on pre-increment 00:00.
    bus.btn_start = 1'b1; bus.btn_sec = 1'b1; tick();
    ex("start_pre_inc", 16'h0001, 0, 0, 1, 0, 0, 0);
    bus.btn_start = 1'b0; bus.btn_sec = 1'b0; tick();

    // 00:02 start: one load cycle, count_zero in it ignored.
    press_sec();
    bus.btn_start = 1'b1; tick();
    ex("load_cycle", 16'h0002, 1, 0, 0, 1, 0, 0);
    bus.btn_start = 1'b0; bus.count_zero = 1'b1; tick();
    ex("cz_in_load", 16'h0002, 0, 1, 0, 1, 0, 0);
    bus.count_zero = 1'b0;
    bus.pulse_1s = 1'b1; tick();
    ex("run_led_tog", 16'h0002, 0, 1, 0, 1, 1, 0);
    bus.pulse_1s = 1'b0; tick();

    // Buttons other than start ignored in RUN.
    press_sec();
    press_min();
    ex("run_ign_btn", 16'h0002, 0, 1, 0, 1, 1, 0);

    // Pause, resume without load, pause, cancel to PROG.
    bus.btn_start = 1'b1; tick();
    ex("pause", 16'h0002, 0, 0, 0, 1, 1, 0);
    bus.btn_start = 1'b0; tick();
    bus.btn_start = 1'b1; tick();
    ex("resume", 16'h0002, 0, 1, 0, 1, 0, 0);
    bus.btn_start = 1'b0; tick();
    press_start();
    press_sec();
    ex("cancel", 16'h0002, 0, 0, 1, 0, 0, 0);

    // count_zero beats start edge; alarm lasts 3 ticks.
    press_start();
    bus.count_zero = 1'b1; bus.btn_start = 1'b1; tick();
    ex("done_entry", 16'h0002, 0, 0, 0, 0, 1, 1);
    bus.count_zero = 1'b0; bus.btn_start = 1'b0; tick();
    ex("done_hold", 16'h0002, 0, 0, 0, 0, 1, 1);
    bus.pulse_1s = 1'b1; tick();
    ex("done_tick1", 16'h0002, 0, 0, 0, 0, 0, 1);
    bus.pulse_1s = 1'b0; tick();
    pulse();
    bus.pulse_1s = 1'b1; tick();
    ex("done_tick3", 16'h0002, 0, 0, 0, 0, 0, 1);
    bus.pulse_1s = 1'b0; tick();
    ex("done_exit", 16'h0002, 0, 0, 1, 0, 0, 0);

    // DONE left by a button edge; digits untouched.
    press_start();
    bus.count_zero = 1'b1; tick();
    bus.count_zero = 1'b0; tick();
    press_min();
    ex("done_btn_exit", 16'h0002, 0, 0, 1, 0, 0, 0);

    // Buttons held through reset release produce no edge.
    reset = 1'b1; bus.btn_start = 1'b1; bus.btn_sec = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    ex("held_rel", 16'h0000, 0, 0, 1, 0, 0, 0);
    tick();
    ex("held_rel2", 16'h0000, 0, 0, 1, 0, 0, 0);
    bus.btn_start = 1'b0; bus.btn_sec = 1'b0; tick();

    // Reset mid-RUN.
    press_sec(); press_sec();
    press_start();
    ex("run_pre_rst", 16'h0002, 0, 1, 0, 1, 0, 0);
    reset = 1'b1; tick();
    ex("rst_mid_run", 16'h0000, 0, 0, 1, 0, 0, 0);
    reset = 1'b0; tick();
    ex("post_rst", 16'h0000, 0, 0, 1, 0, 0, 0);

    tick();
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/eggtimer_ctrl.md
EGGTIMER_CTRL -- requirements
Module: eggtimer_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter: ALARM_SECS, default 30, number of pulse_1s ticks the alarm stays in DONE; legal range >= 1.
REQ-003 Ports, one per line:
  clk  input  1  system clock (5 MHz domain)
  reset  input  1  synchronous, active-high
  pulse_1s  input  1  one-cycle tick, once per second
  btn_start  input  1  start/pause level, already synchronized and debounced
  btn_min  input  1  minutes-increment level, already synchronized and debounced
  btn_sec  input  1  seconds-increment / cancel level, already synchronized and debounced
  count_zero  input  1  time counter reads 00:00
  seconds_prog  output  4  programmed seconds units, BCD 0-9
  tens_seconds_prog  output  4  programmed seconds tens, BCD 0-5
  minutes_prog  output  4  programmed minutes units, BCD 0-9
  tens_minutes_prog  output  4  programmed minutes tens, BCD 0-9
  load  output  1  one-cycle pulse; counter loads the *_prog digits
  count_en  output  1  counter decrements on count_en and pulse_1s
  display_prog  output  1  high = display shows the programmed time
  timer_enabled_led  output  1  high in RUN or PAUSE
  timer_on_led  output  1  run/alarm flash indicator
  alarm  output  1  high in DONE

Function
REQ-004 SHALL detect rising edges per button: edge = btn & ~btn_q, where btn_q is the previous-cycle sample; all edge actions take effect at the same clock edge.
REQ-005 SHALL implement FSM states PROG, RUN, PAUSE, DONE; display_prog = (state==PROG); alarm = (state==DONE); timer_enabled_led = (state==RUN or PAUSE).
REQ-006 In PROG, a btn_sec edge SHALL increment the seconds field BCD 00->59, wrapping 59->00 with no carry into minutes.
REQ-007 In PROG, a btn_min edge SHALL increment the minutes field BCD 00->99, wrapping 99->00.
REQ-008 Simultaneous btn_sec and btn_min edges in PROG SHALL both apply in the same cycle.
REQ-009 A btn_start edge in PROG with programmed time nonzero SHALL enter RUN and assert load for exactly the first RUN cycle; with programmed time 00:00 it SHALL be ignored.
REQ-010 A btn_start edge in PROG simultaneous with a btn_sec or btn_min edge: increments SHALL apply and the start decision SHALL use the pre-increment value.
REQ-011 count_en SHALL be 1 in RUN except in the load cycle, and 0 in all other states.
REQ-012 In RUN, count_zero with load low SHALL enter DONE next cycle; this SHALL take priority over a simultaneous btn_start edge; count_zero during the load cycle SHALL be ignored.
REQ-013 In RUN, a btn_start edge SHALL enter PAUSE; btn_min and btn_sec SHALL be ignored.
REQ-014 In PAUSE, a btn_start edge SHALL return to RUN without asserting load; a btn_sec edge SHALL cancel to PROG; btn_start takes priority over btn_sec.
REQ-015 The *_prog digits SHALL change only in PROG and SHALL be retained across RUN, PAUSE and DONE.
REQ-016 On DONE entry the alarm counter SHALL clear; each pulse_1s in DONE SHALL increment it; when the count reaches ALARM_SECS, or on any button edge, the FSM SHALL enter PROG.
REQ-017 timer_on_led SHALL be:
  - 0 in PROG;
  - 1 in PAUSE;
  - in RUN: cleared on RUN entry, then toggled on each pulse_1s;
  - in DONE: set on DONE entry, then toggled on each pulse_1s.
REQ-018 Alarm counter width SHALL be ceil(log2(ALARM_SECS+1)) bits, and it SHALL never wrap.

Reset
REQ-019 Reset SHALL take priority over all other inputs and SHALL set: state=PROG, all *_prog=0, alarm counter=0, load=0, count_en=0, timer_on_led=0, alarm=0.
REQ-020 During reset btn_q SHALL load the current button levels, so buttons held through reset release generate no edge.
REQ-021 Reset asserted mid-RUN or mid-DONE SHALL return to PROG on the next cycle, with load never asserted.

Verification
REQ-022 Reset, 75 btn_sec edges, 3 btn_min edges -> prog 03:15; display_prog=1.
REQ-023 Prog 00:00, btn_start edge -> stays PROG, load=0; prog 00:02, btn_start -> load high exactly 1 cycle; count_en=0 in that cycle, then 1.
REQ-024 In RUN, btn_start edge -> PAUSE, count_en=0, timer_on_led=1; btn_start -> RUN, no load; btn_sec in PAUSE -> PROG, prog retained.
REQ-025 count_zero asserted together with btn_start edge in RUN -> DONE, alarm=1; with ALARM_SECS=3, after 3 pulse_1s -> PROG, alarm=0.
REQ-026 btn_start held high through reset release -> no transition, no load; reset mid-RUN -> PROG next cycle, prog=00:00.
